// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_pkg
//  Brief    : Shared pipeline constants and the fetch-queue entry type.
//  Revision : 1.0
// ============================================================================
package fetch_unit_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetchEntry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Brief    : Small synchronous FIFO of {instr, pc} entries with clear.
//  Revision : 1.0
// ============================================================================
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetchEntry_t            wrData,
    output fetchEntry_t            rdData,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    fetchEntry_t      r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (push) r_wrPtr <= r_wrPtr + 1'b1;
            if (pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (push && !clear) r_mem[r_wrPtr] <= wrData;
    end

    assign rdData = r_mem[r_rdPtr];
    assign count  = r_count;
    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/flopenrc.sv
`default_nettype none
// ============================================================================
//  Module   : flopenrc
//  Brief    : Enabled flop with synchronous clear (clear beats enable).
//  Revision : 1.0
// ============================================================================
module flopenrc #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= RESET_VAL;
        else if (clr) q <= CLR_VAL;
        else if (en)  q <= d;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : RV32 IF stage: PC, imem request/grant, instruction queue, IF/ID.
//  Revision : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          MAX_OUT  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRValid,
    input  logic [XLEN-1:0] ImemRData,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int IW = $clog2(MAX_OUT + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [XLEN-1:0]   r_pcF;
    logic [XLEN-1:0]   r_respPC;
    logic [IW-1:0]     r_inflight;
    logic [IW-1:0]     r_drop;

    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    fetchEntry_t       w_head;
    fetchEntry_t       w_wrEntry;
    logic [SW-1:0]     w_credit;
    logic              w_issue;
    logic              w_accept;
    logic              w_push;
    logic              w_loadHead;
    logic              w_pop;
    logic [XLEN:0]     w_instrValidD;
    logic [XLEN:0]     w_instrValidQ;
    logic [2*XLEN-1:0] w_pcQ;

    assign w_credit = SW'(w_count) + SW'(r_inflight);
    assign w_issue  = !reset && !PCSrcE && (r_inflight < IW'(MAX_OUT))
                      && (w_credit < SW'(QDEPTH));
    assign w_accept = w_issue && ImemGnt;
    assign ImemReq  = w_issue;
    assign ImemAddr = r_pcF;

    assign w_push     = ImemRValid && !PCSrcE && (r_drop == '0);
    assign w_loadHead = !PCSrcE && !w_empty;
    assign w_pop      = w_loadHead && !StallD && !FlushD;
    assign w_wrEntry  = '{instr: ImemRData, pc: r_respPC};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcF      <= RESET_PC;
            r_respPC   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            case ({w_accept, ImemRValid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (PCSrcE) begin
                r_pcF    <= PCTargetE;
                r_respPC <= PCTargetE;
                // Everything still outstanding after this cycle is stale; drop
                // is a subset of inflight, so it is replaced, not accumulated.
                r_drop   <= r_inflight - IW'(ImemRValid);
            end else begin
                if (w_accept) r_pcF <= r_pcF + 32'd4;
                if (ImemRValid) begin
                    if (r_drop != '0) r_drop   <= r_drop - 1'b1;
                    else              r_respPC <= r_respPC + 32'd4;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .clear  (PCSrcE),
        .wrData (w_wrEntry),
        .rdData (w_head),
        .count  (w_count),
        .full   (w_full),
        .empty  (w_empty)
    );

    assert property (@(posedge clk) disable iff (reset) !(w_push && w_full));

    // Instruction/valid flush to a bubble; the PC pair only moves on a pop.
    assign w_instrValidD = w_loadHead ? {w_head.instr, 1'b1} : {NOP_INSTR, 1'b0};

    flopenrc #(
        .WIDTH     (XLEN + 1),
        .RESET_VAL ({NOP_INSTR, 1'b0}),
        .CLR_VAL   ({NOP_INSTR, 1'b0})
    ) u_instrReg (
        .clk   (clk),
        .reset (reset),
        .en    (!StallD),
        .clr   (FlushD),
        .d     (w_instrValidD),
        .q     (w_instrValidQ)
    );

    flopenrc #(
        .WIDTH (2 * XLEN)
    ) u_pcReg (
        .clk   (clk),
        .reset (reset),
        .en    (w_pop),
        .clr   (1'b0),
        .d     ({w_head.pc, w_head.pc + 32'd4}),
        .q     (w_pcQ)
    );

    assign {InstrD, ValidD}  = w_instrValidQ;
    assign {PCD, PCPlus4D}   = w_pcQ;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Directed + random bench for fetch_unit with a request-level model.
//  Revision : 1.0
// ============================================================================
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int QDEPTH  = 2;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        ImemGnt = 1'b0, ImemRValid = 1'b0;
    logic [31:0] ImemRData = '0;
    logic        ImemReq, ValidD;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (QDEPTH),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemGnt    (ImemGnt),
        .ImemRValid (ImemRValid),
        .ImemRData  (ImemRData),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    // Model: outstanding memory requests (tagged stale on redirect) and the
    // words returned but not yet consumed by decode.
    typedef struct { logic [31:0] pc; bit stale; int ready; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    req_t        outst[$];
    ent_t        iq[$];
    logic [31:0] mPc;
    logic [31:0] eInstr, ePcD, ePc4;
    logic        eValid;
    int          cyc, lat;
    bit          randResp;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] memWord(input logic [31:0] pc);
        return {pc[31:2], 2'b11} ^ 32'h3C00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        ImemGnt = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        ImemRValid = 1'b0; ImemRData = '0;
        #1;
        chk("rst_InstrD", InstrD, NOP_INSTR);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'h0);
        chk("rst_ImemReq", 32'(ImemReq), 32'h0);
        chk("rst_ImemAddr", ImemAddr, 32'h0);
        outst.delete(); iq.delete();
        mPc = 32'h0; eInstr = NOP_INSTR; ePcD = '0; ePc4 = '0; eValid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive inputs after the falling edge, check request outputs,
    // advance the model at the rising edge, check IF/ID at the next fall.
    task automatic cycle(input logic gnt, input logic stall, input logic flush,
                         input logic redir, input logic [31:0] tgt);
        logic        rv, eReq, acc;
        logic [31:0] rd;
        req_t        r;
        ent_t        e;
        rv = (outst.size() > 0) && (cyc >= outst[0].ready)
             && (!randResp || $urandom_range(0, 3) != 0);
        rd = rv ? memWord(outst[0].pc) : 32'h0;
        ImemGnt = gnt; StallD = stall; FlushD = flush; PCSrcE = redir;
        PCTargetE = tgt; ImemRValid = rv; ImemRData = rd;
        eReq = !redir && (outst.size() < MAX_OUT) && ((iq.size() + outst.size()) < QDEPTH);
        #1;
        chk("ImemReq", 32'(ImemReq), 32'(eReq));
        chk("ImemAddr", ImemAddr, mPc);
        @(posedge clk);
        if (flush) begin
            eInstr = NOP_INSTR; eValid = 1'b0;
        end else if (!stall) begin
            if (!redir && iq.size() > 0) begin
                e = iq.pop_front();
                eInstr = e.instr; ePcD = e.pc; ePc4 = e.pc + 32'd4; eValid = 1'b1;
            end else begin
                eInstr = NOP_INSTR; eValid = 1'b0;
            end
        end
        if (rv) begin
            r = outst.pop_front();
            if (!r.stale && !redir) iq.push_back('{instr: rd, pc: r.pc});
        end
        acc = eReq && gnt;
        if (redir) begin
            foreach (outst[k]) outst[k].stale = 1'b1;
            iq.delete();
            mPc = tgt;
        end else if (acc) begin
            outst.push_back('{pc: mPc, stale: 1'b0,
                              ready: cyc + (randResp ? int'($urandom_range(1, 3)) : lat)});
            mPc = mPc + 32'd4;
        end
        cyc++;
        @(negedge clk);
        chk("InstrD", InstrD, eInstr);
        chk("PCD", PCD, ePcD);
        chk("PCPlus4D", PCPlus4D, ePc4);
        chk("ValidD", 32'(ValidD), 32'(eValid));
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        do begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end while (ValidD !== 1'b1 && n < 40);
        chk({tag, "_valid"}, 32'(ValidD), 32'h1);
    endtask

    initial begin
        logic [31:0] holdInstr, holdPc;
        int          n;
        lat = 1; randResp = 1'b0; cyc = 0;

        #2 doReset();
        waitValid("s1a"); chk("s1_pc0", PCD, 32'h0);
        waitValid("s1b"); chk("s1_pc1", PCD, 32'h4); chk("s1_pc1p4", PCPlus4D, 32'h8);
        waitValid("s1c"); chk("s1_pc2", PCD, 32'h8);

        holdInstr = InstrD; holdPc = PCD;
        repeat (4) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_instr", InstrD, holdInstr);
            chk("stall_pc", PCD, holdPc);
        end
        #1 chk("stall_req_low", 32'(ImemReq), 32'h0);
        waitValid("rel"); chk("rel_next_pc", PCD, holdPc + 32'd4);

        doReset();
        n = 0;
        while (mPc != 32'h10 && n < 40) begin cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); n++; end
        chk("gnt_setup", ImemAddr, 32'h10);
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk("gnt_hold", ImemAddr, 32'h10);
        end
        n = 0;
        do begin cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); n++; end
        while (ImemAddr == 32'h10 && n < 5);
        chk("gnt_next", ImemAddr, 32'h14);

        doReset(); lat = 3;
        n = 0;
        while (!(mPc == 32'h28 && outst.size() == 2) && n < 60) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0); n++;
        end
        chk("rd2_setup", ImemAddr, 32'h28);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
        waitValid("rd2"); chk("rd2_pc", PCD, 32'h100); chk("rd2_pc4", PCPlus4D, 32'h104);
        lat = 1;

        doReset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        waitValid("rdr"); chk("rdr_pc", PCD, 32'h200);

        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        waitValid("wr0"); chk("wrap_pc0", PCD, 32'hFFFF_FFF8);
        waitValid("wr1"); chk("wrap_pc1", PCD, 32'hFFFF_FFFC); chk("wrap_pc1p4", PCPlus4D, 32'h0);
        waitValid("wr2"); chk("wrap_pc2", PCD, 32'h0);

        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("flush_stall_instr", InstrD, NOP_INSTR);
        chk("flush_stall_valid", 32'(ValidD), 32'h0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        doReset();
        waitValid("post_rst"); chk("post_rst_pc", PCD, 32'h0);

        randResp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 1) != 0 ? 32'hFFFF_FF00 : 32'h0000_1000)
                + 32'($urandom_range(0, 63) << 2);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
